seletor_aprovados: RTL and testbench

- Stage directly downstream of the active-node evaluator.
- Consumes the evaluator's approved-entry bitmask and picks one approved slot at a time, round-robin.
- Reads that slot's node address and distance through the evaluator's slot read port, then issues the node to the expansion stage over a valid/ready handshake.
- On acceptance, pulses the evaluator's remove port for that node.

---
 rtl/seletor_aprovados.sv | 130 +++++++++++++
 tb/tb_seletor_aprovados.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seletor_aprovados.sv
// Round-robin selector of approved evaluator slots: reads the chosen slot,
// offers it to the expansion stage over valid/ready and pulses a removal on acceptance.
module seletor_aprovados #(
  parameter int BUFFER_SIZE = 16,
  parameter int IDX_WIDTH   = 4,
  parameter int NODE_WIDTH  = 8,
  parameter int DIST_WIDTH  = 8,
  parameter int CONT_WIDTH  = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   habilitar_in,
  input  logic [BUFFER_SIZE-1:0] aprovados_in,
  output logic [IDX_WIDTH-1:0]   sel_indice_out,
  input  logic [NODE_WIDTH-1:0]  endereco_no_in,
  input  logic [DIST_WIDTH-1:0]  distancia_in,
  output logic                   no_valido_out,
  output logic [NODE_WIDTH-1:0]  no_endereco_out,
  output logic [DIST_WIDTH-1:0]  no_distancia_out,
  input  logic                   no_pronto_in,
  output logic                   remover_out,
  output logic [NODE_WIDTH-1:0]  remover_endereco_no_out,
  output logic                   ocioso_out,
  output logic [CONT_WIDTH-1:0]  contagem_emitidos_out
);

  typedef enum logic [1:0] {OCIOSO, LEITURA, EMITE, REMOCAO} state_t;

  state_t               state, state_next;
  logic [IDX_WIDTH-1:0] ptr, idx;
  logic [CONT_WIDTH-1:0] contagem;
  logic                 pick_en, capture, accept;

  // Lowest set bit at or above start; falls back to the lowest set bit overall.
  function automatic logic [IDX_WIDTH-1:0] rr_pick(input logic [BUFFER_SIZE-1:0] mask,
                                                   input logic [IDX_WIDTH-1:0]   start);
    logic [IDX_WIDTH-1:0] low_any, low_hi;
    logic                 hit_hi;
    low_any = '0;
    low_hi  = '0;
    hit_hi  = 1'b0;
    for (int i = BUFFER_SIZE - 1; i >= 0; i--) begin
      if (mask[i]) begin
        low_any = IDX_WIDTH'(i);
        if (i >= int'(start)) begin
          low_hi = IDX_WIDTH'(i);
          hit_hi = 1'b1;
        end
      end
    end
    return hit_hi ? low_hi : low_any;
  endfunction

  function automatic logic [IDX_WIDTH-1:0] wrap_next(input logic [IDX_WIDTH-1:0] v);
    return (v == IDX_WIDTH'(BUFFER_SIZE - 1)) ? '0 : v + IDX_WIDTH'(1);
  endfunction

  function automatic logic [CONT_WIDTH-1:0] sat_inc(input logic [CONT_WIDTH-1:0] v);
    return (&v) ? v : v + CONT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= OCIOSO;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    pick_en    = 1'b0;
    capture    = 1'b0;
    accept     = 1'b0;
    case (state)
      OCIOSO: begin
        if (habilitar_in && (|aprovados_in)) begin
          pick_en    = 1'b1;
          state_next = LEITURA;
        end
      end
      LEITURA: begin
        // The approval may have vanished since the pick; then drop the attempt silently.
        if (aprovados_in[idx]) begin
          capture    = 1'b1;
          state_next = EMITE;
        end else begin
          state_next = OCIOSO;
        end
      end
      EMITE: begin
        if (no_pronto_in) begin
          accept     = 1'b1;
          state_next = REMOCAO;
        end
      end
      REMOCAO: state_next = OCIOSO;
      default: state_next = OCIOSO;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ptr                     <= '0;
      idx                     <= '0;
      no_valido_out           <= 1'b0;
      no_endereco_out         <= '0;
      no_distancia_out        <= '0;
      remover_out             <= 1'b0;
      remover_endereco_no_out <= '0;
      contagem                <= '0;
    end else begin
      remover_out <= accept;
      if (pick_en) idx <= rr_pick(aprovados_in, ptr);
      if (capture) begin
        no_valido_out    <= 1'b1;
        no_endereco_out  <= endereco_no_in;
        no_distancia_out <= distancia_in;
      end
      if (accept) begin
        no_valido_out           <= 1'b0;
        remover_endereco_no_out <= no_endereco_out;
        ptr                     <= wrap_next(idx);
        contagem                <= sat_inc(contagem);
      end
    end
  end

  assign sel_indice_out        = idx;
  assign ocioso_out            = (state == OCIOSO);
  assign contagem_emitidos_out = contagem;

endmodule

// File: tb/tb_seletor_aprovados.sv
// Directed bench for seletor_aprovados: per-cycle comparison against a
// transaction-level model plus hand-computed literal expectations.
module tb_seletor_aprovados;

  logic        clk;
  logic        rst_n;
  logic        habilitar;
  logic [15:0] aprovados;
  logic [3:0]  sel_indice;
  logic [7:0]  endereco_no, distancia;
  logic        no_valido;
  logic [7:0]  no_endereco, no_distancia;
  logic        no_pronto;
  logic        remover;
  logic [7:0]  remover_endereco;
  logic        ocioso;
  logic [15:0] contagem;

  // Narrow-counter copy sharing the stimulus, used to reach counter saturation.
  logic [3:0]  s_sel;
  logic        s_valido, s_remover, s_ocioso;
  logic [7:0]  s_end, s_dist, s_rend, s_end_in, s_dist_in;
  logic [2:0]  s_contagem;

  logic [7:0]  mem_addr [16];
  logic [7:0]  mem_dist [16];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  assign endereco_no = mem_addr[sel_indice];
  assign distancia   = mem_dist[sel_indice];
  assign s_end_in    = mem_addr[s_sel];
  assign s_dist_in   = mem_dist[s_sel];

  seletor_aprovados dut (
    .clk_in(clk), .rst_n_in(rst_n), .habilitar_in(habilitar), .aprovados_in(aprovados),
    .sel_indice_out(sel_indice), .endereco_no_in(endereco_no), .distancia_in(distancia),
    .no_valido_out(no_valido), .no_endereco_out(no_endereco), .no_distancia_out(no_distancia),
    .no_pronto_in(no_pronto), .remover_out(remover), .remover_endereco_no_out(remover_endereco),
    .ocioso_out(ocioso), .contagem_emitidos_out(contagem)
  );

  seletor_aprovados #(.CONT_WIDTH(3)) dut_sat (
    .clk_in(clk), .rst_n_in(rst_n), .habilitar_in(habilitar), .aprovados_in(aprovados),
    .sel_indice_out(s_sel), .endereco_no_in(s_end_in), .distancia_in(s_dist_in),
    .no_valido_out(s_valido), .no_endereco_out(s_end), .no_distancia_out(s_dist),
    .no_pronto_in(no_pronto), .remover_out(s_remover), .remover_endereco_no_out(s_rend),
    .ocioso_out(s_ocioso), .contagem_emitidos_out(s_contagem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // phase: 0 waiting for a pick, 1 reading slot, 2 offering node, 3 removal pulse
  int         phase;
  logic [3:0] m_slot, m_ptr;
  logic       e_valid, e_rem;
  logic [7:0] e_addr, e_dist, e_raddr;
  int         e_count;

  function automatic logic [3:0] next_approved(input logic [15:0] m, input logic [3:0] from);
    logic [3:0] j;
    for (int k = 0; k < 16; k++) begin
      j = from + 4'(k);
      if (m[j]) return j;
    end
    return from;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 0; m_slot <= 0; m_ptr <= 0; e_valid <= 0; e_rem <= 0;
      e_addr <= 0; e_dist <= 0; e_raddr <= 0; e_count <= 0;
    end else begin
      e_rem <= 1'b0;
      if (phase == 0) begin
        if (habilitar && aprovados != 16'h0) begin
          m_slot <= next_approved(aprovados, m_ptr);
          phase  <= 1;
        end
      end else if (phase == 1) begin
        if (aprovados[m_slot]) begin
          e_valid <= 1'b1;
          e_addr  <= mem_addr[m_slot];
          e_dist  <= mem_dist[m_slot];
          phase   <= 2;
        end else phase <= 0;
      end else if (phase == 2) begin
        if (no_pronto) begin
          e_valid <= 1'b0;
          e_rem   <= 1'b1;
          e_raddr <= e_addr;
          m_ptr   <= m_slot + 4'd1;
          e_count <= e_count + 1;
          phase   <= 3;
        end
      end else phase <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", no_valido, e_valid);
      chk("addr", no_endereco, e_addr);
      chk("dist", no_distancia, e_dist);
      chk("remove", remover, e_rem);
      chk("remove_addr", remover_endereco, e_raddr);
      chk("sel", sel_indice, m_slot);
      chk("idle", ocioso, phase == 0);
      chk("count", contagem, (e_count > 65535) ? 65535 : e_count);
      chk("sat_count", s_contagem, (e_count > 7) ? 7 : e_count);
      chk("sat_valid", s_valido, e_valid);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic issue_one(input logic [15:0] m, input logic [3:0] slot,
                           input logic [7:0] ea, input logic [7:0] ed, input int cnt);
    step(); aprovados = m; habilitar = 1'b1;
    step(); habilitar = 1'b0;
    at_neg(); chk("lit_pick_sel", sel_indice, slot);
    step();
    at_neg(); chk("lit_valid", no_valido, 1); chk("lit_addr", no_endereco, ea);
    chk("lit_dist", no_distancia, ed);
    step();
    at_neg(); chk("lit_remove", remover, 1); chk("lit_remove_addr", remover_endereco, ea);
    chk("lit_count", contagem, cnt);
    step();
  endtask

  logic [7:0] issued [$];

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_addr[i] = 8'h10 + 8'(i);
      mem_dist[i] = 8'h80 + 8'(i);
    end
    mem_addr[5] = 8'h2A;
    mem_dist[5] = 8'h10;
    rst_n = 1'b0; habilitar = 1'b1; aprovados = 16'hFFFF; no_pronto = 1'b1;

    repeat (3) step();
    chk_en = 1;
    at_neg();
    chk("rst_valid", no_valido, 0); chk("rst_idle", ocioso, 1);
    chk("rst_remove", remover, 0); chk("rst_count", contagem, 0); chk("rst_sel", sel_indice, 0);

    // first pick after reset release is slot 0
    step(); rst_n = 1'b1;
    step(); habilitar = 1'b0;
    at_neg(); chk("first_sel", sel_indice, 0); chk("first_idle", ocioso, 0);
    step();
    at_neg(); chk("first_valid", no_valido, 1); chk("first_addr", no_endereco, 8'h10);
    step();
    at_neg(); chk("first_remove", remover, 1); chk("first_count", contagem, 1);
    step();

    // single slot 5: node 0x2A dist 0x10
    issue_one(16'h0020, 4'd5, 8'h2A, 8'h10, 2);

    // two approved slots, wrap via ptr=6
    aprovados = 16'h0021; habilitar = 1'b1; no_pronto = 1'b1;
    for (int c = 0; c < 16; c++) begin
      at_neg();
      if (no_valido && no_pronto) issued.push_back(no_endereco);
    end
    habilitar = 1'b0;
    chk("rr_issued_n", issued.size(), 4);
    if (issued.size() == 4) begin
      chk("rr_0", issued[0], 8'h10); chk("rr_1", issued[1], 8'h2A);
      chk("rr_2", issued[2], 8'h10); chk("rr_3", issued[3], 8'h2A);
    end

    // backpressure: ready low for 3 valid cycles
    step(); aprovados = 16'h0001; habilitar = 1'b1; no_pronto = 1'b0;
    step(); habilitar = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      at_neg(); chk("bp_valid", no_valido, 1); chk("bp_addr", no_endereco, 8'h10);
      chk("bp_remove", remover, 0);
    end
    no_pronto = 1'b1;
    at_neg(); chk("bp_remove_pulse", remover, 1); chk("bp_valid_drop", no_valido, 0);
    chk("bp_count", contagem, 7);
    at_neg(); chk("bp_remove_once", remover, 0);

    // stale approval: slot 3 drops during the read
    step(); aprovados = 16'h0008; habilitar = 1'b1;
    step(); aprovados = 16'h0000; habilitar = 1'b0;
    at_neg(); chk("stale_sel", sel_indice, 3); chk("stale_valid", no_valido, 0);
    step();
    at_neg(); chk("stale_idle", ocioso, 1); chk("stale_remove", remover, 0);
    chk("stale_count", contagem, 7);
    // ptr still 1: with slots 0 and 3 approved, slot 3 is chosen
    issue_one(16'h0009, 4'd3, 8'h13, 8'h83, 8);

    // slot 15 wraps ptr to 0
    issue_one(16'h8000, 4'd15, 8'h1F, 8'h8F, 9);
    issue_one(16'h8001, 4'd0, 8'h10, 8'h80, 10);
    chk("sat_hold", s_contagem, 7);

    // asynchronous reset in the middle of an offer
    step(); aprovados = 16'h0001; habilitar = 1'b1; no_pronto = 1'b0;
    step(); habilitar = 1'b0;
    step();
    at_neg(); chk("ar_valid_before", no_valido, 1);
    #2; rst_n = 1'b0;
    #1;
    chk("ar_valid", no_valido, 0); chk("ar_idle", ocioso, 1);
    chk("ar_remove", remover, 0); chk("ar_count", contagem, 0);
    at_neg(); chk("ar_no_remove", remover, 0);
    step(); rst_n = 1'b1; no_pronto = 1'b1; aprovados = 16'h0000;
    repeat (3) step();
    at_neg(); chk("ar_end_remove", remover, 0);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
